// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator for a word-addressed data memory.
// Handles lane extraction/extension on loads and read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int unsigned WORD_ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dm_we,
    output logic        dm_re,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned
);

    typedef enum logic {IDLE, RMW_WRITE} state_t;

    state_t                    state_q, state_d;
    logic [31:0]               rmw_word_q, rmw_word_d;
    logic [1:0]                rmw_lane_q, rmw_lane_d;
    logic                      rmw_half_q, rmw_half_d;
    logic [15:0]               rmw_data_q, rmw_data_d;
    logic [WORD_ADDR_BITS-1:0] rmw_idx_q, rmw_idx_d;
    logic [31:0]               load_data_q, load_data_d;
    logic                      load_valid_q, load_valid_d;
    logic                      misaligned_q, misaligned_d;

    logic                      is_b, is_h, is_w, legal, reject;
    logic [1:0]                lane;
    logic [WORD_ADDR_BITS-1:0] idx;
    logic [31:0]               shifted, extracted, merged;

    assign lane = addr[1:0];
    assign idx  = addr[WORD_ADDR_BITS+1:2];
    assign is_b = (funct3[1:0] == 2'b00);
    assign is_h = (funct3[1:0] == 2'b01);
    assign is_w = (funct3 == 3'b010);

    // Unsigned variants exist only for loads; stores accept b/h/w only.
    assign legal  = is_w || ((is_b || is_h) && !(mem_write && funct3[2]));
    assign reject = (mem_read && mem_write) || !legal
                 || (is_h && addr[0]) || (is_w && (lane != 2'b00));

    always_comb begin
        shifted   = dm_rdata >> {lane, 3'b000};
        extracted = dm_rdata;
        if (is_b) begin
            extracted = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
        end else if (is_h) begin
            extracted = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
        end
    end

    always_comb begin
        merged = rmw_word_q;
        if (rmw_half_q) begin
            if (rmw_lane_q[1]) merged[31:16] = rmw_data_q;
            else               merged[15:0]  = rmw_data_q;
        end else begin
            case (rmw_lane_q)
                2'd0:    merged[7:0]   = rmw_data_q[7:0];
                2'd1:    merged[15:8]  = rmw_data_q[7:0];
                2'd2:    merged[23:16] = rmw_data_q[7:0];
                default: merged[31:24] = rmw_data_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        rmw_word_d   = rmw_word_q;
        rmw_lane_d   = rmw_lane_q;
        rmw_half_d   = rmw_half_q;
        rmw_data_d   = rmw_data_q;
        rmw_idx_d    = rmw_idx_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misaligned_d = 1'b0;
        dm_we        = 1'b0;
        dm_re        = 1'b0;
        dm_addr      = '0;
        dm_wdata     = '0;
        stall        = 1'b0;
        // Reset gates the memory interface combinationally so a pending RMW write never lands.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req_valid && (mem_read || mem_write)) begin
                        if (reject) begin
                            misaligned_d = 1'b1;
                        end else if (mem_read) begin
                            dm_re                        = 1'b1;
                            dm_addr[WORD_ADDR_BITS-1:0]  = idx;
                            load_data_d                  = extracted;
                            load_valid_d                 = 1'b1;
                        end else if (is_w) begin
                            dm_we                        = 1'b1;
                            dm_addr[WORD_ADDR_BITS-1:0]  = idx;
                            dm_wdata                     = store_data;
                        end else begin
                            dm_re                        = 1'b1;
                            dm_addr[WORD_ADDR_BITS-1:0]  = idx;
                            stall                        = 1'b1;
                            rmw_word_d                   = dm_rdata;
                            rmw_lane_d                   = lane;
                            rmw_half_d                   = is_h;
                            rmw_data_d                   = store_data[15:0];
                            rmw_idx_d                    = idx;
                            state_d                      = RMW_WRITE;
                        end
                    end
                end
                RMW_WRITE: begin
                    dm_we                        = 1'b1;
                    dm_addr[WORD_ADDR_BITS-1:0]  = rmw_idx_q;
                    dm_wdata                     = merged;
                    state_d                      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rmw_word_q   <= '0;
            rmw_lane_q   <= '0;
            rmw_half_q   <= 1'b0;
            rmw_data_q   <= '0;
            rmw_idx_q    <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rmw_word_q   <= rmw_word_d;
            rmw_lane_q   <= rmw_lane_d;
            rmw_half_q   <= rmw_half_d;
            rmw_data_q   <= rmw_data_d;
            rmw_idx_q    <= rmw_idx_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: bench-side reference memory predicts load
// results, RMW write data and reject pulses; a 256-word memory model serves the DUT.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        dm_we, dm_re, stall, load_valid, misaligned;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, load_data;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        mem_clr;

    typedef struct {
        logic        is_mis;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.WORD_ADDR_BITS(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .store_data(store_data),
        .dm_we(dm_we), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .misaligned(misaligned)
    );

    assign dm_rdata = dm_re ? mem[dm_addr[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (dm_we) begin
            mem[dm_addr[7:0]] <= dm_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = ref_mem[a[9:2]];
        case (a[1:0])
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return b[7]  ? {24'hFFFFFF, b} : {24'h0, b};
            3'b100:  return {24'h0, b};
            3'b001:  return h[15] ? {16'hFFFF, h} : {16'h0, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] sd);
        logic [31:0] w;
        w = ref_mem[a[9:2]];
        if (f3 == 3'b010) return sd;
        if (f3 == 3'b001) begin
            if (a[1]) w[31:16] = sd[15:0];
            else      w[15:0]  = sd[15:0];
            return w;
        end
        w[a[1:0]*8 +: 8] = sd[7:0];
        return w;
    endfunction

    always @(negedge clk) begin
        if (dm_we && dm_re) check("we_re_excl", 32'd1, 32'd0);
        if (!rst && (load_valid || misaligned)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {30'b0, load_valid, misaligned}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("mis_pulse", {31'b0, misaligned}, {31'b0, e.is_mis});
                check("lv_pulse", {31'b0, load_valid}, {31'b0, !e.is_mis});
                if (!e.is_mis) check("load_data", load_data, e.data);
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        @(negedge clk);
        req_valid  = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a);
        exp_t e;
        e.is_mis = 1'b0;
        e.data   = model_load(f3, a);
        issue(1'b1, 1'b0, f3, a, 32'h0);
        check("ld_re", {31'b0, dm_re}, 32'd1);
        check("ld_we", {31'b0, dm_we}, 32'd0);
        check("ld_stall", {31'b0, stall}, 32'd0);
        check("ld_addr", dm_addr, {24'h0, a[9:2]});
        sb_q.push_back(e);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
        logic [31:0] w;
        w = model_store(f3, a, sd);
        issue(1'b0, 1'b1, f3, a, sd);
        if (f3 == 3'b010) begin
            check("sw_we", {31'b0, dm_we}, 32'd1);
            check("sw_stall", {31'b0, stall}, 32'd0);
        end else begin
            check("rmw_re", {31'b0, dm_re}, 32'd1);
            check("rmw_stall", {31'b0, stall}, 32'd1);
            check("rmw_addr0", dm_addr, {24'h0, a[9:2]});
            @(negedge clk);
            #1;
            check("rmw_we", {31'b0, dm_we}, 32'd1);
            check("rmw_re2", {31'b0, dm_re}, 32'd0);
            check("rmw_stall2", {31'b0, stall}, 32'd0);
        end
        check("st_addr", dm_addr, {24'h0, a[9:2]});
        check("st_wdata", dm_wdata, w);
        ref_mem[a[9:2]] = w;
    endtask

    task automatic do_reject(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a);
        exp_t e;
        e.is_mis = 1'b1;
        e.data   = 32'h0;
        issue(rd, wr, f3, a, 32'h1234_5678);
        check("rej_we", {31'b0, dm_we}, 32'd0);
        check("rej_re", {31'b0, dm_re}, 32'd0);
        check("rej_stall", {31'b0, stall}, 32'd0);
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  lf3 [5];
        logic [2:0]  f3;
        logic [31:0] a;
        lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b0; addr = 32'h0; store_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;
        #1;
        check("rst_we", {31'b0, dm_we}, 32'd0);
        check("rst_re", {31'b0, dm_re}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_lv", {31'b0, load_valid}, 32'd0);
        check("rst_mis", {31'b0, misaligned}, 32'd0);
        check("rst_ld", load_data, 32'h0);

        // req_valid low blocks access even with mem_read/mem_write set
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b1; funct3 = 3'b010; addr = 32'h14;
        #1;
        check("noreq_we", {31'b0, dm_we}, 32'd0);
        check("noreq_re", {31'b0, dm_re}, 32'd0);

        do_store(3'b010, 32'h14, 32'h8);
        do_store(3'b010, 32'h18, 32'h1);
        do_load(3'b010, 32'h14);
        do_store(3'b000, 32'h15, 32'hAB);
        do_load(3'b010, 32'h14);
        do_store(3'b001, 32'h1A, 32'hBEEF);
        do_load(3'b001, 32'h1A);
        do_load(3'b101, 32'h1A);
        do_store(3'b000, 32'h18, 32'h80);
        do_load(3'b000, 32'h18);
        do_load(3'b100, 32'h18);
        do_load(3'b010, 32'h18);

        do_reject(1'b1, 1'b0, 3'b010, 32'h16);
        do_reject(1'b0, 1'b1, 3'b001, 32'h19);
        do_reject(1'b1, 1'b0, 3'b011, 32'h14);
        do_reject(1'b1, 1'b1, 3'b010, 32'h14);
        do_reject(1'b0, 1'b1, 3'b100, 32'h14);
        idle(2);

        // Reset during RMW_WRITE must suppress the write
        issue(1'b0, 1'b1, 3'b000, 32'h15, 32'hCD);
        check("rst6_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst6_we", {31'b0, dm_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        check("rst6_we2", {31'b0, dm_we}, 32'd0);
        check("rst6_stall2", {31'b0, stall}, 32'd0);
        do_load(3'b010, 32'h414);

        for (int n = 0; n < 24; n++) begin
            a = {20'h0, 2'($urandom_range(0, 3)), 2'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                f3 = lf3[$urandom_range(0, 4)];
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3 == 3'b010) a[1:0] = 2'b00;
                do_load(f3, a);
            end else begin
                f3 = lf3[$urandom_range(0, 2)];
                if (f3 == 3'b001) a[0] = 1'b0;
                if (f3 == 3'b010) a[1:0] = 2'b00;
                do_store(f3, a, $urandom());
            end
        end

        idle(3);
        check("sb_drain", sb_q.size(), 32'd0);
        for (int i = 0; i < 8; i++) check("mem_final", mem[i], ref_mem[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
